// File: rtl/maj_net_sequencer.sv
// Time-multiplexed evaluator for programmable MAJ-3 gate networks over NUM_IN primary inputs.
// One gate per cycle is resolved from a loaded program; the last gate's value is returned over valid/ready.
module maj_net_sequencer #(
    parameter int NUM_IN    = 7,
    parameter int MAX_GATES = 8,
    parameter int SEL_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [3*SEL_W-1:0] cfg_data,
    input  logic               cfg_len_we,
    input  logic [3:0]         cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out,
    output logic               busy,
    output logic               cfg_err
);

    localparam int OPS_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [3*SEL_W-1:0]     prog_r [MAX_GATES];
    logic [3:0]             len_r;
    logic [NUM_IN-1:0]      x_r;
    logic [MAX_GATES-1:0]   w_r;
    logic [2:0]             k_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   out_r;
    logic                   busy_r;
    logic                   cfg_err_r;

    logic                   idle_s;
    logic                   addr_ok_s;
    logic                   len_legal_s;
    logic                   slot_wr_s;
    logic                   len_wr_s;
    logic                   cfg_err_s;
    logic [3:0]             len_nxt_s;
    logic [3*SEL_W-1:0]     gate_s;
    logic [OPS_W-1:0]       ops_s;
    logic                   res_s;
    logic                   last_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Config write qualification: writes land only in IDLE and only with legal values
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        addr_ok_s   = (int'(cfg_addr) < MAX_GATES);
        len_legal_s = (cfg_len != 4'd0) && (int'(cfg_len) <= MAX_GATES);
        slot_wr_s   = cfg_we && idle_s && addr_ok_s;
        len_wr_s    = cfg_len_we && idle_s && len_legal_s;
        cfg_err_s   = (cfg_we && !slot_wr_s) || (cfg_len_we && !len_wr_s);
        if (len_wr_s) begin
            len_nxt_s = cfg_len;
        end else begin
            len_nxt_s = len_r;
        end
    end

    // Operand space is {w, x, 0} so a selector indexes it directly; w regs not yet written read 0
    always_comb begin
        ops_s                      = '0;
        ops_s[NUM_IN+MAX_GATES:0]  = {w_r, x_r, 1'b0};
        gate_s                     = prog_r[k_r];
        res_s  = maj3(ops_s[gate_s[SEL_W-1:0]],
                      ops_s[gate_s[2*SEL_W-1:SEL_W]],
                      ops_s[gate_s[3*SEL_W-1:2*SEL_W]]);
        last_s = ({1'b0, k_r} == (len_r - 4'd1));
    end

    // Program store, length and rejected-write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_GATES; i++) begin
                prog_r[i] <= '0;
            end
            len_r     <= 4'd0;
            cfg_err_r <= 1'b0;
        end else begin
            if (slot_wr_s) begin
                prog_r[cfg_addr] <= cfg_data;
            end
            len_r     <= len_nxt_s;
            cfg_err_r <= cfg_err_s;
        end
    end

    // Sequencer FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            x_r         <= '0;
            w_r         <= '0;
            k_r         <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_r        <= x;
                        w_r        <= '0;
                        k_r        <= 3'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_EVAL;
                    end else begin
                        in_ready_r <= (len_nxt_s != 4'd0);
                    end
                end
                ST_EVAL: begin
                    w_r[k_r] <= res_s;
                    if (last_s) begin
                        out_r       <= res_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= (len_r != 4'd0);
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Scoreboard bench for maj_net_sequencer: a behavioural network model predicts each result and its
// arrival cycle; a negedge monitor pops and compares whenever a new result is presented.
module tb_maj_net_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_len_we;
    logic [3:0]  cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  x;
    logic        out_valid;
    logic        out_ready;
    logic        out;
    logic        busy;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

    bit exp_q[$];
    int due_q[$];
    bit seen = 1'b0;

    int m_a[8];
    int m_b[8];
    int m_c[8];
    int m_len = 0;

    maj_net_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input int sel, input logic [6:0] xv, input logic [7:0] w);
        if (sel == 0) return 0;
        else if (sel <= 7) return int'(xv[sel-1]);
        else return int'(w[sel-8]);
    endfunction

    // Evaluate the programmed network gate by gate; unevaluated gates are still 0.
    function automatic bit model_eval(input logic [6:0] xv);
        logic [7:0] w;
        int va, vb, vc;
        w = 8'd0;
        for (int k = 0; k < m_len; k++) begin
            va = pick(m_a[k], xv, w);
            vb = pick(m_b[k], xv, w);
            vc = pick(m_c[k], xv, w);
            w[k] = ((va + vb + vc) >= 2);
        end
        if (m_len == 0) return 1'b0;
        return w[m_len-1];
    endfunction

    // Monitor: a new result is one whose out_valid was low at the previous sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && !seen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                chk("out", out, exp_q.pop_front());
                chk("latency", cyc, due_q.pop_front());
            end
            seen <= 1'b1;
        end
        if (!out_valid) seen <= 1'b0;
    end

    task automatic cfg_write(input bit we, input int addr, input int a, input int b, input int c,
                             input bit lwe, input int l, input bit idle, input string name);
        bit slot_ok, len_ok;
        @(negedge clk);
        cfg_we     = we;
        cfg_addr   = addr[2:0];
        cfg_data   = {c[3:0], b[3:0], a[3:0]};
        cfg_len_we = lwe;
        cfg_len    = l[3:0];
        slot_ok = idle && addr >= 0 && addr < 8;
        len_ok  = idle && l >= 1 && l <= 8;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_len_we = 1'b0;
        chk(name, cfg_err, int'((we && !slot_ok) || (lwe && !len_ok)));
        if (we && slot_ok) begin
            m_a[addr] = a;
            m_b[addr] = b;
            m_c[addr] = c;
        end
        if (lwe && len_ok) m_len = l;
    endtask

    task automatic send(input logic [6:0] xv);
        bit ok;
        @(negedge clk);
        in_valid = 1'b1;
        x        = xv;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", ok, 1);
        if (ok) begin
            exp_q.push_back(model_eval(xv));
            due_q.push_back(cyc + 1 + m_len);
            last_acc = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        x        = 7'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1);
    endtask

    task automatic burst(input int n, input bit rnd, input logic [6:0] v0, input logic [6:0] v1,
                         input logic [6:0] v2, input logic [6:0] v3);
        int prev;
        logic [6:0] v;
        for (int j = 0; j < n; j++) begin
            case (j)
                0: v = v0;
                1: v = v1;
                2: v = v2;
                default: v = v3;
            endcase
            if (rnd) v = 7'($urandom);
            prev = last_acc;
            send(v);
            if (j > 0) chk("throughput", last_acc - prev, m_len + 2);
        end
        drain();
    endtask

    task automatic load_spec_program();
        cfg_write(1'b1, 0, 2, 3, 4, 1'b0, 0, 1'b1, "cfg_slot0");
        cfg_write(1'b1, 1, 1, 3, 5, 1'b0, 0, 1'b1, "cfg_slot1");
        cfg_write(1'b1, 2, 1, 6, 8, 1'b0, 0, 1'b1, "cfg_slot2");
        cfg_write(1'b1, 3, 1, 3, 4, 1'b0, 0, 1'b1, "cfg_slot3");
        cfg_write(1'b1, 4, 7, 10, 11, 1'b0, 0, 1'b1, "cfg_slot4");
        cfg_write(1'b1, 5, 2, 9, 12, 1'b1, 6, 1'b1, "cfg_slot5_len6");
    endtask

    task automatic load_random_program(input int len);
        for (int g = 0; g < 8; g++) begin
            cfg_write(1'b1, g, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), g == 7, len, 1'b1, "cfg_rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 12'd0;
        cfg_len_we = 1'b0; cfg_len = 4'd0; in_valid = 1'b0; x = 7'd0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_c[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        // len=0: a pending vector must not be accepted
        in_valid = 1'b1; x = 7'h7f;
        repeat (4) begin
            @(negedge clk);
            chk("len0_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // Single-gate program: w0 = maj(x0, x1, 0)
        cfg_write(1'b1, 0, 1, 2, 0, 1'b1, 1, 1'b1, "cfg_len1");
        burst(3, 1'b0, 7'b0000011, 7'b0000001, 7'b0000010, 7'b0);

        // Reference six-gate network, including back-to-back throughput
        load_spec_program();
        burst(4, 1'b0, 7'b0000111, 7'b0000101, 7'b1111111, 7'b0000000);

        // Consumer stall in DONE
        out_ready = 1'b0;
        e = model_eval(7'b0000111);
        send(7'b0000111);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out", out, e);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        drain();

        // Config writes while evaluating are rejected
        send(7'b0000101);
        cfg_write(1'b1, 0, 15, 15, 15, 1'b1, 3, 1'b0, "cfg_err_eval");
        @(negedge clk);
        chk("cfg_err_pulse_end", cfg_err, 0);
        drain();
        burst(2, 1'b0, 7'b0000111, 7'b0010011, 7'b0, 7'b0);

        // Illegal lengths are rejected and len stays 6
        cfg_write(1'b0, 0, 0, 0, 0, 1'b1, 0, 1'b1, "cfg_err_len0");
        cfg_write(1'b0, 0, 0, 0, 0, 1'b1, 9, 1'b1, "cfg_err_len9");
        burst(2, 1'b0, 7'b1111111, 7'b1010101, 7'b0, 7'b0);

        // Random programs and vectors
        for (int p = 0; p < 5; p++) begin
            load_random_program(int'($urandom_range(1, 8)));
            burst(6, 1'b1, 7'b0, 7'b0, 7'b0, 7'b0);
        end

        // Asynchronous reset in the middle of an evaluation
        load_random_program(8);
        send(7'($urandom));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        due_q.delete();
        m_len = 0;
        for (int i = 0; i < 8; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_c[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 0);
        load_spec_program();
        burst(3, 1'b0, 7'b0000111, 7'b0000101, 7'b1100011, 7'b0);
        load_random_program(int'($urandom_range(1, 8)));
        burst(4, 1'b1, 7'b0, 7'b0, 7'b0, 7'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
